// File: rtl/lcd_pkg.sv
// Shared constants, types and helpers for the character-LCD bus responder.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package lcd_pkg;

    // Command codes: each command is identified by its leading one bit.
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPCTL = 8'h08;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    localparam logic [7:0] SPACE_CHAR_DEF = 8'h20;

    // DDRAM line bases and the last address of each line before wrapping.
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_END  = 7'h27;
    localparam logic [6:0] LINE2_END  = 7'h67;

    // Controller state encoding.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // One assembled bus byte.
    typedef struct packed {
        logic       rs;
        logic [7:0] dat;
    } lcd_byte_t;

    // Visible-cell lookup result for a DDRAM address.
    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } scr_slot_t;

    // True when b's leading one is exactly the bit set in code.
    function automatic logic cmd_match(input logic [7:0] b, input logic [7:0] code);
        logic [7:0] upper;
        upper = ~(code | (code - 8'd1));
        return ((b & upper) == 8'h00) && ((b & code) != 8'h00);
    endfunction

    // Map a DDRAM address to a shadow-screen cell; only the first 16
    // columns of each line are visible.
    function automatic scr_slot_t addr_to_slot(input logic [6:0] addr);
        scr_slot_t s;
        s.hit = 1'b0;
        s.idx = 5'd0;
        if (addr[6:4] == LINE1_BASE[6:4]) begin
            s.hit = 1'b1;
            s.idx = {1'b0, addr[3:0]};
        end else if (addr[6:4] == LINE2_BASE[6:4]) begin
            s.hit = 1'b1;
            s.idx = {1'b1, addr[3:0]};
        end
        return s;
    endfunction

    // Address counter step with the two-line wrap of the controller.
    function automatic logic [6:0] cursor_step(input logic [6:0] addr, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (addr == LINE1_END)
                nxt = LINE2_BASE;
            else if (addr == LINE2_END)
                nxt = LINE1_BASE;
            else
                nxt = addr + 7'd1;
        end else begin
            if (addr == LINE1_BASE)
                nxt = LINE2_END;
            else if (addr == LINE2_BASE)
                nxt = LINE1_END;
            else
                nxt = addr - 7'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_nibble_assembler.sv
// Detects LCDE falling edges and assembles bus nibbles into bytes (8-bit or 4-bit mode).
// Latency: byte_vld rises on the clock edge that sees the completing falling edge.
// Backpressure: none; the LCD bus cannot be stalled, so every completed write byte is emitted.
module lcd_nibble_assembler
    import lcd_pkg::*;
(
    input  logic       CCLK,
    input  logic       rst,
    input  logic       LCDE,
    input  logic       LCDRS,
    input  logic       LCDRW,
    input  logic [3:0] LCDDAT,
    input  logic       four_bit,
    input  logic       phase_clr,
    output logic       byte_vld,
    output lcd_byte_t  byte_dat,
    output logic       rs_err_vld
);

    logic       e_q;
    logic       strobe;
    logic       phase_lo;
    logic [3:0] hi_nib;
    logic       hi_rs;
    logic       hi_rw;

    assign strobe = e_q & ~LCDE;

    // Strobe capture, nibble phase tracking and byte assembly.
    always_ff @(posedge CCLK) begin
        if (rst) begin
            e_q        <= 1'b0;
            phase_lo   <= 1'b0;
            hi_nib     <= 4'h0;
            hi_rs      <= 1'b0;
            hi_rw      <= 1'b0;
            byte_vld   <= 1'b0;
            byte_dat   <= '0;
            rs_err_vld <= 1'b0;
        end else begin
            e_q        <= LCDE;
            byte_vld   <= 1'b0;
            rs_err_vld <= 1'b0;
            if (strobe) begin
                if (!four_bit) begin
                    // 8-bit mode: only the upper data lines are wired.
                    phase_lo <= 1'b0;
                    if (!LCDRW) begin
                        byte_vld     <= 1'b1;
                        byte_dat.rs  <= LCDRS;
                        byte_dat.dat <= {LCDDAT, 4'h0};
                    end
                end else if (!phase_lo) begin
                    // High nibble: hold it until the partner arrives.
                    phase_lo <= 1'b1;
                    hi_nib   <= LCDDAT;
                    hi_rs    <= LCDRS;
                    hi_rw    <= LCDRW;
                end else begin
                    // Low nibble: reads still consume the phase, but emit nothing.
                    phase_lo <= 1'b0;
                    if (!LCDRW && !hi_rw) begin
                        byte_vld     <= 1'b1;
                        byte_dat.rs  <= LCDRS;
                        byte_dat.dat <= {hi_nib, LCDDAT};
                        rs_err_vld   <= (hi_rs != LCDRS);
                    end
                end
            end
            // A function-set realigns the next strobe to the high nibble.
            if (phase_clr)
                phase_lo <= 1'b0;
        end
    end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Responder for the 4-bit HD44780-style bus: decodes commands/data into a 2x16 shadow screen.
// Latency: state updates one cycle after byte_valid; clear sweeps 32 cycles with busy high.
// Backpressure: none; bytes completing during a clear are dropped and flag err.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter bit         INIT_4BIT  = 1'b0,
    parameter logic [7:0] SPACE_CHAR = SPACE_CHAR_DEF
) (
    input  logic         CCLK,
    input  logic         rst,
    input  logic         LCDE,
    input  logic         LCDRS,
    input  logic         LCDRW,
    input  logic [3:0]   LCDDAT,
    output logic [255:0] screen,
    output logic [6:0]   cursor_addr,
    output logic         disp_on,
    output logic         four_bit,
    output logic         busy,
    output logic         byte_valid,
    output logic         byte_rs,
    output logic [7:0]   byte_data,
    output logic         err
);

    logic             asm_vld;
    logic             asm_rs_err;
    lcd_byte_t        asm_byte;
    logic             phase_clr;

    logic [0:0]       state;
    logic [4:0]       clr_idx;
    logic             inc_q;
    logic [6:0]       cur_q;
    logic             disp_q;
    logic             four_q;
    logic             err_q;
    logic [0:31][7:0] scr;

    logic             idle;
    logic             cmd_vld;
    logic             data_vld;
    scr_slot_t        slot;

    lcd_nibble_assembler u_asm (
        .CCLK       (CCLK),
        .rst        (rst),
        .LCDE       (LCDE),
        .LCDRS      (LCDRS),
        .LCDRW      (LCDRW),
        .LCDDAT     (LCDDAT),
        .four_bit   (four_q),
        .phase_clr  (phase_clr),
        .byte_vld   (asm_vld),
        .byte_dat   (asm_byte),
        .rs_err_vld (asm_rs_err)
    );

    assign idle      = (state == ST_IDLE);
    assign cmd_vld   = asm_vld & idle & ~asm_byte.rs;
    assign data_vld  = asm_vld & idle &  asm_byte.rs;
    assign phase_clr = cmd_vld & cmd_match(asm_byte.dat, CMD_FUNC);
    assign slot      = addr_to_slot(cur_q);

    // Command decode, address counter and clear sequencing.
    always_ff @(posedge CCLK) begin
        if (rst) begin
            state   <= ST_IDLE;
            clr_idx <= 5'd0;
            inc_q   <= 1'b1;
            cur_q   <= 7'h00;
            disp_q  <= 1'b0;
            four_q  <= INIT_4BIT;
            err_q   <= 1'b0;
        end else begin
            if (asm_rs_err)
                err_q <= 1'b1;
            if (state == ST_CLEAR) begin
                if (asm_vld)
                    err_q <= 1'b1;
                clr_idx <= clr_idx + 5'd1;
                if (clr_idx == 5'd31)
                    state <= ST_IDLE;
            end else if (data_vld) begin
                cur_q <= cursor_step(cur_q, inc_q);
            end else if (cmd_vld) begin
                if (cmd_match(asm_byte.dat, CMD_DDRAM)) begin
                    cur_q <= asm_byte.dat[6:0];
                end else if (cmd_match(asm_byte.dat, CMD_FUNC)) begin
                    four_q <= ~asm_byte.dat[4];
                end else if (cmd_match(asm_byte.dat, CMD_DISPCTL)) begin
                    disp_q <= asm_byte.dat[2];
                end else if (cmd_match(asm_byte.dat, CMD_ENTRY)) begin
                    inc_q <= asm_byte.dat[1];
                end else if (cmd_match(asm_byte.dat, CMD_HOME)) begin
                    cur_q <= LINE1_BASE;
                end else if (cmd_match(asm_byte.dat, CMD_CLEAR)) begin
                    cur_q   <= LINE1_BASE;
                    clr_idx <= 5'd0;
                    state   <= ST_CLEAR;
                end
            end
        end
    end

    // Shadow screen: clear sweeps one cell per cycle, data lands in its mapped cell.
    always_ff @(posedge CCLK) begin
        if (rst)
            scr <= {32{SPACE_CHAR}};
        else if (state == ST_CLEAR)
            scr[clr_idx] <= SPACE_CHAR;
        else if (data_vld && slot.hit)
            scr[slot.idx] <= asm_byte.dat;
    end

    assign screen      = scr;
    assign cursor_addr = cur_q;
    assign disp_on     = disp_q;
    assign four_bit    = four_q;
    assign busy        = (state == ST_CLEAR);
    assign byte_valid  = asm_vld;
    assign byte_rs     = asm_byte.rs;
    assign byte_data   = asm_byte.dat;
    assign err         = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver: directed bus traffic with a byte scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_bus_receiver;

    logic         CCLK = 1'b0;
    logic         rst;
    logic         LCDE;
    logic         LCDRS;
    logic         LCDRW;
    logic [3:0]   LCDDAT;
    logic [255:0] screen;
    logic [6:0]   cursor_addr;
    logic         disp_on;
    logic         four_bit;
    logic         busy;
    logic         byte_valid;
    logic         byte_rs;
    logic [7:0]   byte_data;
    logic         err;

    localparam logic [255:0] ALL_SP = {32{8'h20}};

    int         total = 0;
    int         bad = 0;
    int         busy_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;

    always #5 CCLK = ~CCLK;

    lcd_bus_receiver #(.INIT_4BIT(1'b0), .SPACE_CHAR(8'h20)) dut (
        .CCLK        (CCLK),
        .rst         (rst),
        .LCDE        (LCDE),
        .LCDRS       (LCDRS),
        .LCDRW       (LCDRW),
        .LCDDAT      (LCDDAT),
        .screen      (screen),
        .cursor_addr (cursor_addr),
        .disp_on     (disp_on),
        .four_bit    (four_bit),
        .busy        (busy),
        .byte_valid  (byte_valid),
        .byte_rs     (byte_rs),
        .byte_data   (byte_data),
        .err         (err)
    );

    // Scoreboard monitor: every byte_valid pops and compares one expected byte.
    always @(negedge CCLK) begin
        if (byte_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL byte_sb unexpected byte got rs=%0d data=%02h", byte_rs, byte_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({byte_rs, byte_data} !== mon_exp) begin
                    bad++;
                    $display("FAIL byte_sb got rs=%0d data=%02h want rs=%0d data=%02h",
                             byte_rs, byte_data, mon_exp[8], mon_exp[7:0]);
                end
            end
        end
        if (busy)
            busy_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CCLK);
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [3:0] nib);
        LCDRS  = rs;
        LCDRW  = rw;
        LCDDAT = nib;
        LCDE   = 1'b1;
        tick(2);
        LCDE   = 1'b0;
        tick(3);
    endtask

    task automatic send8(input logic rs, input logic [3:0] nib);
        exp_q.push_back({rs, nib, 4'h0});
        strobe(rs, 1'b0, nib);
    endtask

    task automatic send4(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b});
        strobe(rs, 1'b0, b[7:4]);
        strobe(rs, 1'b0, b[3:0]);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_scr(input string name, input logic [255:0] want);
        total++;
        if (screen !== want) begin
            bad++;
            $display("FAIL %s got=%064h want=%064h", name, screen, want);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic init4();
        send8(1'b0, 4'h3);
        send8(1'b0, 4'h3);
        send8(1'b0, 4'h3);
        send8(1'b0, 4'h2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b1;
        LCDE   = 1'b0;
        LCDRS  = 1'b0;
        LCDRW  = 1'b0;
        LCDDAT = 4'h0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check_scr("rst_screen", ALL_SP);
        check("rst_cursor", {25'd0, cursor_addr}, 32'h00);
        check("rst_four_bit", {31'd0, four_bit}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_disp_on", {31'd0, disp_on}, 32'd0);
        check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);

        // 8-bit power-up sequence switches to 4-bit
        init4();
        check("init_four_bit", {31'd0, four_bit}, 32'd1);

        // Function set, display on, entry mode, clear
        send4(1'b0, 8'h28);
        check("func_four_bit", {31'd0, four_bit}, 32'd1);
        send4(1'b0, 8'h0C);
        check("disp_on_set", {31'd0, disp_on}, 32'd1);
        send4(1'b0, 8'h06);
        busy_cnt = 0;
        send4(1'b0, 8'h01);
        wait_idle("clear1_idle");
        check("clear1_busy_cycles", busy_cnt, 32'd32);
        check_scr("clear1_screen", ALL_SP);
        check("clear1_cursor", {25'd0, cursor_addr}, 32'h00);

        // Line 2 writes
        send4(1'b0, 8'hC0);
        send4(1'b1, 8'h41);
        send4(1'b1, 8'h42);
        check("l2_char16", {24'd0, screen[127:120]}, 32'h41);
        check("l2_char17", {24'd0, screen[119:112]}, 32'h42);
        check("l2_cursor", {25'd0, cursor_addr}, 32'h42);

        // End of visible line 1: second write falls off-screen
        send4(1'b0, 8'h8F);
        send4(1'b1, 8'h5A);
        send4(1'b1, 8'h5A);
        check("col15_char", {24'd0, screen[135:128]}, 32'h5A);
        check("col15_no_spill", {16'd0, screen[127:112]}, 32'h4142);
        check("col15_cursor", {25'd0, cursor_addr}, 32'h11);

        // Decrement wraps 0x00 -> 0x67
        send4(1'b0, 8'h04);
        send4(1'b0, 8'h80);
        send4(1'b1, 8'h55);
        check("dec_wrap_cursor", {25'd0, cursor_addr}, 32'h67);
        check("dec_wrap_char0", {24'd0, screen[255:248]}, 32'h55);

        // Decrement wraps 0x40 -> 0x27
        send4(1'b0, 8'hC0);
        send4(1'b1, 8'h2E);
        check("dec_l2_cursor", {25'd0, cursor_addr}, 32'h27);
        check("dec_l2_char16", {24'd0, screen[127:120]}, 32'h2E);

        // Increment wraps 0x67 -> 0x00 and 0x27 -> 0x40, hidden writes dropped
        send4(1'b0, 8'h06);
        send4(1'b0, 8'hE7);
        send4(1'b1, 8'h3F);
        check("inc_wrap67_cursor", {25'd0, cursor_addr}, 32'h00);
        check("inc_wrap67_char0", {24'd0, screen[255:248]}, 32'h55);
        send4(1'b0, 8'hA7);
        send4(1'b1, 8'h21);
        check("inc_wrap27_cursor", {25'd0, cursor_addr}, 32'h40);
        check_scr("hidden_writes_screen",
                  {8'h55, {14{8'h20}}, 8'h5A, 8'h2E, 8'h42, {14{8'h20}}});

        // Home and display off
        send4(1'b0, 8'h02);
        check("home_cursor", {25'd0, cursor_addr}, 32'h00);
        send4(1'b0, 8'h08);
        check("disp_off", {31'd0, disp_on}, 32'd0);

        // Read strobes: no byte, no state change
        strobe(1'b1, 1'b1, 4'h4);
        strobe(1'b1, 1'b1, 4'h1);
        check("read_cursor", {25'd0, cursor_addr}, 32'h00);
        check("read_char0", {24'd0, screen[255:248]}, 32'h55);

        // Data during clear is dropped and flags err
        check("pre_busy_err", {31'd0, err}, 32'd0);
        busy_cnt = 0;
        send4(1'b0, 8'h01);
        send4(1'b1, 8'h77);
        wait_idle("clear2_idle");
        check("busy_drop_err", {31'd0, err}, 32'd1);
        check_scr("clear2_screen", ALL_SP);
        check("busy_drop_cursor", {25'd0, cursor_addr}, 32'h00);
        check("clear2_busy_cycles", busy_cnt, 32'd32);

        // Reset clears err; RS mismatch between nibbles
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst2_err", {31'd0, err}, 32'd0);
        check("rst2_four_bit", {31'd0, four_bit}, 32'd0);
        init4();
        exp_q.push_back({1'b1, 8'h4B});
        strobe(1'b0, 1'b0, 4'h4);
        strobe(1'b1, 1'b0, 4'hB);
        check("rs_mismatch_err", {31'd0, err}, 32'd1);
        check("rs_mismatch_byte_rs", {31'd0, byte_rs}, 32'd1);
        check("rs_mismatch_char0", {24'd0, screen[255:248]}, 32'h4B);

        // Reset in the middle of a clear
        send4(1'b0, 8'hCF);
        send4(1'b1, 8'h58);
        check("char31", {24'd0, screen[7:0]}, 32'h58);
        send4(1'b0, 8'h01);
        tick(5);
        check("midclear_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midclear_rst_busy", {31'd0, busy}, 32'd0);
        check_scr("midclear_rst_screen", ALL_SP);
        tick(2);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
